// File: rtl/shifter_arb_pkg.sv
// Shared constants and types for the round-robin rotate arbiter.
// No logic; imported by the picker and the top.
// Widths here fix every port width in the block.
package shifter_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [1:0]       id;
        logic [WIDTH-1:0] data;
    } result_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set req at or above ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is accepted.
module rr_pick4
    import shifter_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [1:0]         idx,
    output logic               any
);

    logic       found;
    logic [1:0] cand;

    assign any = |req;

    // 2-bit candidate index wraps 3 -> 0 on its own.
    always_comb begin
        pick  = '0;
        idx   = 2'd0;
        found = 1'b0;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                pick[cand] = 1'b1;
                idx        = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shifter_rr_arbiter.sv
// Shares one 4-bit rotator among four requesters, round-robin, with a registered result.
// Latency: gnt in cycle N gives out_valid with that result in cycle N+1.
// Backpressure: result held while out_ready is low; a new accept may coincide with a drain.
module shifter_rr_arbiter
    import shifter_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*2-1:0]       req_shamt,
    input  logic [NUM_REQ-1:0]         req_dir,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [1:0]                 out_id,
    input  logic                       out_ready
);

    state_t             state, state_nxt;
    logic [1:0]         ptr;
    result_t            res_q;

    logic [NUM_REQ-1:0] pick;
    logic [1:0]         idx;
    logic               any;
    logic               accept;

    logic [WIDTH-1:0]   win_data;
    logic [1:0]         win_shamt;
    logic               win_dir;
    logic [WIDTH-1:0]   rot;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx),
        .any  (any)
    );

    assign accept = any && ((state == IDLE) || out_ready);
    assign gnt    = (accept && rst_n) ? pick : '0;

    assign win_data  = req_data[{idx, 2'b00} +: WIDTH];
    assign win_shamt = req_shamt[{idx, 1'b0} +: 2];
    assign win_dir   = req_dir[idx];

    // One 4:1 mux per output bit; the select is the source bit index mod 4.
    for (genvar k = 0; k < WIDTH; k++) begin : g_rot
        logic [1:0] sel;
        assign sel    = (win_dir == DIR_RIGHT) ? (2'(k) + win_shamt) : (2'(k) - win_shamt);
        assign rot[k] = win_data[sel];
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr        <= idx + 2'd1;
                res_q.id   <= idx;
                res_q.data <= rot;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = res_q.data;
    assign out_id    = res_q.id;

endmodule
